cv32e40p_multi_sleep_unit: RTL and testbench



---
 rtl/cv32e40p_pkg.sv | 18 +
 rtl/cv32e40p_sim_clock_gating.sv | 20 ++
 rtl/cv32e40p_sleep_domain_fsm.sv | 102 ++++++++++
 rtl/cv32e40p_multi_sleep_unit.sv | 58 +++++
 tb/tb_cv32e40p_multi_sleep_unit.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cv32e40p_pkg.sv
// Shared types for the cv32e40p sleep/clock-gating slice.
package cv32e40p_pkg;

   // Per-domain sleep controller states
   typedef enum logic [2:0] {
      SD_RESET = 3'd0,
      SD_RUN   = 3'd1,
      SD_IDLE  = 3'd2,
      SD_GATED = 3'd3,
      SD_WAKE  = 3'd4
   } sleep_dom_state_e;

   // Larger of two parameter values, used to size shared counters
   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/cv32e40p_sim_clock_gating.sv
// Behavioural latch-based clock gate; enable captured while the clock is low.
module cv32e40p_sim_clock_gating (
   input  logic clk_i,
   input  logic en_i,
   input  logic scan_cg_en_i,
   output logic clk_o
);

   logic clk_en;

   // Transparent-low latch keeps the gated clock glitch-free
   always_latch begin
      if (clk_i == 1'b0) begin
         clk_en <= en_i | scan_cg_en_i;
      end
   end

   assign clk_o = clk_i & clk_en;

endmodule

// File: rtl/cv32e40p_sleep_domain_fsm.sv
// One gated clock domain: sleep FSM, shared hysteresis/wake counter, clock gate.
module cv32e40p_sleep_domain_fsm
   import cv32e40p_pkg::*;
#(
   parameter int unsigned IDLE_HOLD = 4,
   parameter int unsigned WAKE_LAT  = 1
) (
   input  logic clk_ungated_i,
   input  logic rst_n,
   input  logic scan_cg_en_i,
   input  logic fetch_enable_q,
   input  logic busy,
   input  logic sleep_req,
   input  logic wake,
   output logic clk_gated,
   output logic ready,
   output logic sleep
);

   localparam int unsigned CNT_W = $clog2(max_u(IDLE_HOLD, WAKE_LAT) + 1);
   localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_HOLD - 1);
   localparam logic [CNT_W-1:0] WAKE_LOAD = (WAKE_LAT > 0) ? CNT_W'(WAKE_LAT - 1) : '0;

   sleep_dom_state_e state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             en;

   // State and counter registers on the free-running clock
   always_ff @(posedge clk_ungated_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SD_RESET;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and counter update; wake always wins over sleep entry
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         SD_RESET: begin
            if (fetch_enable_q) state_d = SD_RUN;
         end
         SD_RUN: begin
            if (sleep_req && !busy && !wake) begin
               state_d = SD_IDLE;
               cnt_d   = IDLE_LOAD;
            end
         end
         SD_IDLE: begin
            if (busy || wake || !sleep_req) begin
               state_d = SD_RUN;
            end else if (cnt_q == '0) begin
               state_d = SD_GATED;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         SD_GATED: begin
            if (wake) begin
               if (WAKE_LAT == 0) begin
                  state_d = SD_RUN;
               end else begin
                  state_d = SD_WAKE;
                  cnt_d   = WAKE_LOAD;
               end
            end
         end
         SD_WAKE: begin
            if (cnt_q == '0) state_d = SD_RUN;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         default: state_d = SD_RESET;
      endcase
   end

   // Wake reopens the gate combinationally so the wake cycle gets its edge
   always_comb begin
      en = fetch_enable_q & ((state_q != SD_GATED) | wake);
   end

   assign ready = (state_q == SD_RUN) || (state_q == SD_IDLE);
   assign sleep = (state_q == SD_GATED);

   cv32e40p_sim_clock_gating u_clock_gate (
      .clk_i        (clk_ungated_i),
      .en_i         (en),
      .scan_cg_en_i (scan_cg_en_i),
      .clk_o        (clk_gated)
   );

`ifdef CV32E40P_ASSERT_ON
   a_sleep_gated : assert property (@(posedge clk_ungated_i) disable iff (!rst_n)
      sleep |-> (!en || wake));
   a_en_states : assert property (@(posedge clk_ungated_i) disable iff (!rst_n)
      !en |-> (state_q inside {SD_RESET, SD_GATED}));
`endif

endmodule

// File: rtl/cv32e40p_multi_sleep_unit.sv
// Multi-domain sleep unit: sticky fetch enable plus one gated domain per bit.
module cv32e40p_multi_sleep_unit
   import cv32e40p_pkg::*;
#(
   parameter int unsigned NUM_DOMAINS = 2,
   parameter int unsigned IDLE_HOLD   = 4,
   parameter int unsigned WAKE_LAT    = 1
) (
   input  logic                   clk_ungated_i,
   input  logic                   rst_n,
   input  logic                   scan_cg_en_i,
   input  logic                   fetch_enable_i,
   output logic                   fetch_enable_o,
   input  logic [NUM_DOMAINS-1:0] busy_i,
   input  logic [NUM_DOMAINS-1:0] sleep_req_i,
   input  logic [NUM_DOMAINS-1:0] wake_i,
   output logic [NUM_DOMAINS-1:0] clk_gated_o,
   output logic [NUM_DOMAINS-1:0] domain_ready_o,
   output logic [NUM_DOMAINS-1:0] domain_sleep_o,
   output logic                   core_sleep_o
);

   logic fetch_enable_q;

   // Fetch enable is sticky until reset
   always_ff @(posedge clk_ungated_i or negedge rst_n) begin
      if (!rst_n) fetch_enable_q <= 1'b0;
      else if (fetch_enable_i) fetch_enable_q <= 1'b1;
   end

   assign fetch_enable_o = fetch_enable_q;

   for (genvar g = 0; g < NUM_DOMAINS; g++) begin : gen_domain
      cv32e40p_sleep_domain_fsm #(
         .IDLE_HOLD (IDLE_HOLD),
         .WAKE_LAT  (WAKE_LAT)
      ) u_domain (
         .clk_ungated_i  (clk_ungated_i),
         .rst_n          (rst_n),
         .scan_cg_en_i   (scan_cg_en_i),
         .fetch_enable_q (fetch_enable_q),
         .busy           (busy_i[g]),
         .sleep_req      (sleep_req_i[g]),
         .wake           (wake_i[g]),
         .clk_gated      (clk_gated_o[g]),
         .ready          (domain_ready_o[g]),
         .sleep          (domain_sleep_o[g])
      );
   end

   assign core_sleep_o = &domain_sleep_o;

`ifdef CV32E40P_ASSERT_ON
   a_core_sleep_idle : assert property (@(posedge clk_ungated_i) disable iff (!rst_n)
      core_sleep_o |-> (busy_i == '0));
`endif

endmodule

// File: tb/tb_cv32e40p_multi_sleep_unit.sv
// Bench for cv32e40p_multi_sleep_unit: two instances (WAKE_LAT 2 and 0) share
// stimulus and are compared every cycle against a streak/countdown model.
module tb_cv32e40p_multi_sleep_unit;

   localparam int ND = 2;
   localparam int IH = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n = 1'b0;
   logic          scan_cg_en = 1'b0;
   logic          fetch_enable = 1'b0;
   logic [ND-1:0] busy = '0, sleep_req = '0, wake = '0;

   logic          fe_o [2];
   logic [ND-1:0] cg   [2];
   logic [ND-1:0] rdy  [2];
   logic [ND-1:0] slp  [2];
   logic          core [2];

   cv32e40p_multi_sleep_unit #(.NUM_DOMAINS(ND), .IDLE_HOLD(IH), .WAKE_LAT(2)) u_dut_lat2 (
      .clk_ungated_i (clk), .rst_n (rst_n), .scan_cg_en_i (scan_cg_en),
      .fetch_enable_i (fetch_enable), .fetch_enable_o (fe_o[0]),
      .busy_i (busy), .sleep_req_i (sleep_req), .wake_i (wake),
      .clk_gated_o (cg[0]), .domain_ready_o (rdy[0]), .domain_sleep_o (slp[0]),
      .core_sleep_o (core[0]));

   cv32e40p_multi_sleep_unit #(.NUM_DOMAINS(ND), .IDLE_HOLD(IH), .WAKE_LAT(0)) u_dut_lat0 (
      .clk_ungated_i (clk), .rst_n (rst_n), .scan_cg_en_i (scan_cg_en),
      .fetch_enable_i (fetch_enable), .fetch_enable_o (fe_o[1]),
      .busy_i (busy), .sleep_req_i (sleep_req), .wake_i (wake),
      .clk_gated_o (cg[1]), .domain_ready_o (rdy[1]), .domain_sleep_o (slp[1]),
      .core_sleep_o (core[1]));

   // Model: a domain is either not started, awake (ready), gated, or waking
   // with a number of cycles left. Awake domains count consecutive cycles of
   // the sleep condition; IH+1 of them in a row means gated.
   bit m_fe      [2];
   bit m_started [2][ND];
   bit m_awake   [2][ND];
   bit m_gated   [2][ND];
   int m_wleft   [2][ND];
   int m_streak  [2][ND];

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   function automatic int lat_of(input int i);
      return (i == 0) ? 2 : 0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         m_fe[i] = 1'b0;
         for (int d = 0; d < ND; d++) begin
            m_started[i][d] = 1'b0;
            m_awake[i][d]   = 1'b0;
            m_gated[i][d]   = 1'b0;
            m_wleft[i][d]   = 0;
            m_streak[i][d]  = 0;
         end
      end
   endfunction

   function automatic logic [ND-1:0] model_en(input int i);
      logic [ND-1:0] e;
      for (int d = 0; d < ND; d++)
         e[d] = scan_cg_en | (m_fe[i] & (!m_gated[i][d] | wake[d]));
      return e;
   endfunction

   function automatic void model_edge(input int i);
      for (int d = 0; d < ND; d++) begin
         if (!m_started[i][d]) begin
            if (m_fe[i]) begin
               m_started[i][d] = 1'b1;
               m_awake[i][d]   = 1'b1;
               m_streak[i][d]  = 0;
            end
         end else if (m_awake[i][d]) begin
            if (sleep_req[d] && !busy[d] && !wake[d]) m_streak[i][d]++;
            else                                       m_streak[i][d] = 0;
            if (m_streak[i][d] == IH + 1) begin
               m_awake[i][d]  = 1'b0;
               m_gated[i][d]  = 1'b1;
               m_streak[i][d] = 0;
            end
         end else if (m_gated[i][d]) begin
            if (wake[d]) begin
               m_gated[i][d] = 1'b0;
               if (lat_of(i) == 0) m_awake[i][d] = 1'b1;
               else                m_wleft[i][d] = lat_of(i);
            end
         end else begin
            m_wleft[i][d]--;
            if (m_wleft[i][d] == 0) m_awake[i][d] = 1'b1;
         end
      end
      if (fetch_enable) m_fe[i] = 1'b1;
   endfunction

   task automatic compare_outputs();
      logic [ND-1:0] er, es;
      for (int i = 0; i < 2; i++) begin
         for (int d = 0; d < ND; d++) begin
            er[d] = m_awake[i][d];
            es[d] = m_gated[i][d];
         end
         chk($sformatf("fetch_enable_o[%0d]", i), 32'(fe_o[i]), 32'(m_fe[i]));
         chk($sformatf("domain_ready_o[%0d]", i), 32'(rdy[i]), 32'(er));
         chk($sformatf("domain_sleep_o[%0d]", i), 32'(slp[i]), 32'(es));
         chk($sformatf("core_sleep_o[%0d]", i), 32'(core[i]), 32'(&es));
      end
   endtask

   // One clock: gated-clock level sampled in the high phase, then model update
   task automatic step();
      logic [ND-1:0] en_exp [2];
      for (int i = 0; i < 2; i++) en_exp[i] = model_en(i);
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 2; i++)
         chk($sformatf("clk_gated_o[%0d]", i), 32'(cg[i]), 32'(en_exp[i]));
      if (rst_n) begin
         for (int i = 0; i < 2; i++) model_edge(i);
      end
      compare_outputs();
   endtask

   initial begin
      logic [ND-1:0] cg_seen;
      model_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ready", 32'({rdy[0], rdy[1]}), 32'h0);
      chk("reset_fe", 32'({fe_o[0], fe_o[1]}), 32'h0);
      compare_outputs();
      rst_n = 1'b1;

      // No fetch enable: gates stay shut
      cg_seen = '0;
      repeat (20) begin
         step();
         cg_seen |= cg[0] | cg[1];
      end
      chk("no_gated_edges", 32'(cg_seen), 32'h0);

      // Start-up
      fetch_enable = 1'b1;
      step();
      fetch_enable = 1'b0;
      chk("fe_sticky", 32'(fe_o[0]), 32'h1);
      chk("ready_not_yet", 32'(rdy[0]), 32'h0);
      step();
      chk("ready_up_lat2", 32'(rdy[0]), 32'h3);
      chk("ready_up_lat0", 32'(rdy[1]), 32'h3);

      // Domain 0 gating after IH+1 sleep-condition cycles
      sleep_req = 2'b01;
      repeat (4) step();
      chk("not_gated_yet", 32'(slp[0]), 32'h0);
      step();
      chk("gated_dom0", 32'(slp[0]), 32'h1);
      chk("dom1_ready", 32'(rdy[0]), 32'h2);
      chk("core_awake", 32'(core[0]), 32'h0);

      // Wake: latency 2 vs latency 0
      sleep_req = '0;
      wake = 2'b01;
      step();
      wake = '0;
      chk("wake_edge", 32'(cg[0]), 32'h3);
      chk("in_wake_lat2", 32'(rdy[0]), 32'h2);
      chk("run_lat0", 32'(rdy[1]), 32'h3);
      step();
      chk("still_wake_lat2", 32'(rdy[0]), 32'h2);
      step();
      chk("run_lat2", 32'(rdy[0]), 32'h3);

      // IDLE abort by busy, then a full fresh count
      sleep_req = 2'b01;
      repeat (3) step();
      busy = 2'b01;
      step();
      busy = '0;
      chk("abort_ready", 32'(rdy[0]), 32'h3);
      chk("abort_nosleep", 32'(slp[0]), 32'h0);
      repeat (4) step();
      chk("recount_not_gated", 32'(slp[0]), 32'h0);
      step();
      chk("recount_gated", 32'(slp[0]), 32'h1);

      // Both domains gated
      sleep_req = 2'b11;
      repeat (4) step();
      chk("core_not_yet", 32'(core[0]), 32'h0);
      step();
      chk("core_sleep_lat2", 32'(core[0]), 32'h1);
      chk("core_sleep_lat0", 32'(core[1]), 32'h1);

      // Scan forces gates open without disturbing state
      scan_cg_en = 1'b1;
      step();
      scan_cg_en = 1'b0;
      chk("scan_clock", 32'(cg[0]), 32'h3);
      chk("scan_state", 32'(slp[0]), 32'h3);
      step();

      // Sleep request with concurrent wake never leaves RUN
      wake = 2'b11;
      for (int k = 0; k < 10; k++) begin
         step();
         if (k >= 2) chk("wake_beats_sleep_lat2", 32'(rdy[0]), 32'h3);
         chk("wake_beats_sleep_lat0", 32'(rdy[1]), 32'h3);
      end
      wake = '0;
      sleep_req = '0;
      step();

      // Reset while domain 0 is waking
      sleep_req = 2'b01;
      repeat (5) step();
      sleep_req = '0;
      wake = 2'b01;
      step();
      wake = '0;
      chk("pre_reset_wake", 32'(rdy[0]), 32'h2);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_reset_ready", 32'({rdy[0], rdy[1]}), 32'h0);
      chk("async_reset_sleep", 32'({slp[0], slp[1]}), 32'h0);
      compare_outputs();
      step();
      rst_n = 1'b1;
      repeat (3) step();
      chk("no_restart", 32'(rdy[0]), 32'h0);

      // Randomised traffic
      for (int n = 0; n < 3000; n++) begin
         for (int d = 0; d < ND; d++) begin
            sleep_req[d] = ($urandom_range(0, 7) != 0);
            wake[d]      = ($urandom_range(0, 24) == 0);
            busy[d]      = ($urandom_range(0, 9) == 0) && !m_gated[0][d] && !m_gated[1][d];
         end
         scan_cg_en   = ($urandom_range(0, 49) == 0);
         fetch_enable = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 499) == 0) begin
            rst_n = 1'b0;
            model_reset();
            #1;
            compare_outputs();
            step();
            rst_n = 1'b1;
         end else begin
            step();
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
